vga_sync_decoder: RTL and testbench

//  Receiver end of the VGA sync interface. Watches VGA_HS/VGA_VS as driven by the game's sync

---
 rtl/vga_sync_decoder.sv | 158 +++++++++++++++
 tb/tb_vga_sync_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA sync receiver: recovers pixel position from HS/VS, checks the line and frame
// periods and the HS pulse width, and reports lock, timing errors and a frame count.
module vga_sync_decoder #(
    parameter int unsigned PIXEL_DISPLAY_BIT = 9,
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic                       clock_25,
    input  logic                       reset,
    input  logic                       VGA_HS,
    input  logic                       VGA_VS,
    output logic [PIXEL_DISPLAY_BIT:0] X,
    output logic [PIXEL_DISPLAY_BIT:0] Y,
    output logic                       display_area,
    output logic                       frame_tik,
    output logic                       locked,
    output logic                       sync_error,
    output logic [7:0]                 frame_count
);
    localparam int unsigned CW      = PIXEL_DISPLAY_BIT + 1;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_MAX       = CW'(H_TOTAL);
    localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_LAST = CW'(H_SYNC - 1);
    localparam logic [CW-1:0] H_VIS_LO    = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_VIS_HI    = CW'(H_SYNC + H_BP + H_VIS - 1);
    localparam logic [CW-1:0] V_MAX       = CW'(V_TOTAL);
    localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_VIS_LO    = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_VIS_HI    = CW'(V_SYNC + V_BP + V_VIS - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state;
    logic          hs_s;
    logic          vs_s;
    logic          line_seen;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;

    logic          hs_fall;
    logic          vs_fall;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          hs_bad;
    logic          locking_err;
    logic          locked_err;
    logic          h_vis;
    logic          v_vis;

    // Edge detect against the registered copy, counter next values and error terms
    always_comb begin
        hs_fall = hs_s & ~VGA_HS;
        vs_fall = vs_s & ~VGA_VS;

        h_next = h_cnt;
        if (hs_fall) begin
            h_next = '0;
        end else if (h_cnt != H_MAX) begin
            h_next = h_cnt + CW'(1);
        end

        v_next = v_cnt;
        if (vs_fall) begin
            v_next = '0;
        end else if (hs_fall && (v_cnt != V_MAX)) begin
            v_next = v_cnt + CW'(1);
        end

        // The first HS fall after entering LOCKING has no reference and is not checked
        hs_bad      = (hs_fall && line_seen && (h_cnt != H_LAST)) || (h_cnt == H_MAX);
        locking_err = hs_bad || (vs_fall && !((v_cnt == V_LAST) && line_seen));
        locked_err  = (hs_fall && (h_cnt != H_LAST))
                   || (h_cnt == H_MAX)
                   || (vs_fall && (v_cnt != V_LAST))
                   || (v_cnt == V_MAX)
                   || (VGA_HS && (h_cnt < H_SYNC_LAST));
    end

    // Lock state machine, counters and registered status outputs
    always_ff @(posedge clock_25) begin
        if (reset) begin
            state       <= SEARCH;
            hs_s        <= 1'b1;
            vs_s        <= 1'b1;
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_seen   <= 1'b0;
            locked      <= 1'b0;
            frame_tik   <= 1'b0;
            sync_error  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            hs_s       <= VGA_HS;
            vs_s       <= VGA_VS;
            h_cnt      <= h_next;
            v_cnt      <= v_next;
            frame_tik  <= 1'b0;
            sync_error <= 1'b0;
            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state     <= LOCKING;
                        line_seen <= 1'b0;
                    end
                end
                LOCKING: begin
                    if (locking_err) begin
                        sync_error <= 1'b1;
                        state      <= SEARCH;
                    end else begin
                        if (hs_fall) begin
                            line_seen <= 1'b1;
                        end
                        if (vs_fall) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (locked_err) begin
                        sync_error <= 1'b1;
                        locked     <= 1'b0;
                        state      <= SEARCH;
                    end else if (vs_fall) begin
                        frame_tik   <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Position decode from registered counters; zero unless locked and visible
    assign h_vis        = (h_cnt >= H_VIS_LO) && (h_cnt <= H_VIS_HI);
    assign v_vis        = (v_cnt >= V_VIS_LO) && (v_cnt <= V_VIS_HI);
    assign display_area = locked && h_vis && v_vis;
    assign X            = display_area ? (h_cnt - H_VIS_LO) : '0;
    assign Y            = display_area ? (v_cnt - V_VIS_LO) : '0;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 15x9 timing so that
// several hundred frames fit in a short run.
module tb_vga_sync_decoder;
    localparam int PDB = 4;
    localparam int W   = PDB + 1;
    localparam int HV  = 8;
    localparam int HF  = 2;
    localparam int HSY = 3;
    localparam int HB  = 2;
    localparam int VV  = 4;
    localparam int VF  = 1;
    localparam int VSY = 2;
    localparam int VB  = 2;
    localparam int HT    = HV + HF + HSY + HB;
    localparam int VT    = VV + VF + VSY + VB;
    localparam int FRAME = HT * VT;

    logic         clock_25;
    logic         reset;
    logic         VGA_HS;
    logic         VGA_VS;
    logic [PDB:0] X;
    logic [PDB:0] Y;
    logic         display_area;
    logic         frame_tik;
    logic         locked;
    logic         sync_error;
    logic [7:0]   frame_count;

    vga_sync_decoder #(
        .PIXEL_DISPLAY_BIT(PDB),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
    ) dut (
        .clock_25    (clock_25),
        .reset       (reset),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .X           (X),
        .Y           (Y),
        .display_area(display_area),
        .frame_tik   (frame_tik),
        .locked      (locked),
        .sync_error  (sync_error),
        .frame_count (frame_count)
    );

    initial begin
        clock_25 = 1'b0;
        forever #20 clock_25 = ~clock_25;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int gh, gv, obs_gh, obs_gv;
    int n_err, n_tik, n_da;
    bit hold_hs, hold_vs, short_line, short_pulse;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected {display_area, X, Y} for the generator position last applied
    function automatic logic [31:0] exp_pix(input int h, input int v, input bit lk);
        if (lk && h >= HSY + HB && h <= HSY + HB + HV - 1 &&
            v >= VSY + VB && v <= VSY + VB + VV - 1)
            return 32'({1'b1, W'(h - HSY - HB), W'(v - VSY - VB)});
        return 32'd0;
    endfunction

    // One pixel clock: drive the generator position, sample after the edge, advance
    task automatic cyc();
        VGA_HS = hold_hs ? 1'b1 : (short_pulse ? (gh != 0) : (gh >= HSY));
        VGA_VS = hold_vs ? 1'b1 : (gv >= VSY);
        @(posedge clock_25);
        @(negedge clock_25);
        obs_gh = gh;
        obs_gv = gv;
        if (sync_error)   n_err++;
        if (frame_tik)    n_tik++;
        if (display_area) n_da++;
        if (gh == HT - 1 || (short_line && gh == HT - 2)) begin
            short_line = 1'b0;
            gh = 0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end else begin
            gh = gh + 1;
        end
    endtask

    task automatic run_to(input int th, input int tv, input string tag);
        int n = 0;
        while (!(gh == th && gv == tv) && n < 2 * FRAME) begin
            cyc();
            n++;
        end
        check(tag, 32'(gh == th && gv == tv), 32'd1);
    endtask

    task automatic relock();
        run_to(0, 0, "reach_relock1");
        cyc();
        check("relock_first_vs", 32'(locked), 32'd0);
        run_to(0, 0, "reach_relock2");
        cyc();
        check("relock_second_vs", 32'(locked), 32'd1);
    endtask

    initial begin
        gh = 0; gv = 0;
        hold_hs = 0; hold_vs = 0; short_line = 0; short_pulse = 0;
        n_err = 0; n_tik = 0; n_da = 0;
        reset  = 1'b1;
        VGA_HS = 1'b1;
        VGA_VS = 1'b1;
        repeat (3) begin
            @(posedge clock_25);
            @(negedge clock_25);
        end
        check("rst_x", 32'(X), 32'd0);
        check("rst_y", 32'(Y), 32'd0);
        check("rst_da", 32'(display_area), 32'd0);
        check("rst_tik", 32'(frame_tik), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err", 32'(sync_error), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        reset = 1'b0;

        // Lock acquisition: locked one cycle after the second VS fall
        cyc();
        check("locking_not_locked", 32'(locked), 32'd0);
        run_to(0, 0, "reach_f2");
        check("unlocked_before_2nd_vs", 32'(locked), 32'd0);
        cyc();
        check("locked_after_2nd_vs", 32'(locked), 32'd1);
        check("no_tik_at_lock", 32'(frame_tik), 32'd0);
        check("no_err_while_locking", 32'(n_err), 32'd0);

        // Full frame pixel decode
        n_da = 0; n_tik = 0;
        for (int i = 0; i < FRAME - 1; i++) begin
            cyc();
            check("pix", 32'({display_area, X, Y}), exp_pix(obs_gh, obs_gv, 1'b1));
        end
        check("da_per_frame", 32'(n_da), 32'(HV * VV));
        check("no_tik_midframe", 32'(n_tik), 32'd0);
        cyc();
        check("tik_frame3", 32'(frame_tik), 32'd1);
        check("count_frame3", 32'(frame_count), 32'd1);
        cyc();
        check("tik_one_cycle", 32'(frame_tik), 32'd0);

        // Short line while locked
        run_to(0, 5, "reach_short");
        short_line = 1'b1;
        run_to(0, 6, "reach_after_short");
        check("locked_before_short_fall", 32'(locked), 32'd1);
        n_err = 0;
        cyc();
        check("short_err", 32'(sync_error), 32'd1);
        check("short_unlock", 32'(locked), 32'd0);
        cyc();
        check("short_err_pulse", 32'(sync_error), 32'd0);
        run_to(7, 6, "reach_vis_unlocked");
        cyc();
        check("unlocked_xy_zero", 32'({display_area, X, Y}), 32'd0);
        check("count_held", 32'(frame_count), 32'd1);
        relock();
        check("single_err_short", 32'(n_err), 32'd1);

        // HS stuck high while locked
        run_to(0, 2, "reach_hs_hold");
        hold_hs = 1'b1;
        cyc();
        check("hs_hold_h800_no_err_yet", 32'(sync_error), 32'd0);
        check("hs_hold_still_locked", 32'(locked), 32'd1);
        cyc();
        check("hs_hold_err", 32'(sync_error), 32'd1);
        check("hs_hold_unlock", 32'(locked), 32'd0);
        run_to(0, 3, "reach_hs_release");
        hold_hs = 1'b0;
        relock();

        // VS stuck high while locked
        run_to(0, 0, "reach_vs_hold");
        hold_vs = 1'b1;
        cyc();
        check("vs_hold_no_err_yet", 32'(sync_error), 32'd0);
        check("vs_hold_no_tik", 32'(frame_tik), 32'd0);
        cyc();
        check("vs_hold_err", 32'(sync_error), 32'd1);
        check("vs_hold_unlock", 32'(locked), 32'd0);
        check("vs_hold_count_kept", 32'(frame_count), 32'd1);
        run_to(0, 3, "reach_vs_release");
        hold_vs = 1'b0;
        relock();

        // HS pulse only one cycle wide
        run_to(0, 2, "reach_short_pulse");
        short_pulse = 1'b1;
        cyc();
        check("pulse_fall_ok", 32'(sync_error), 32'd0);
        cyc();
        check("pulse_short_err", 32'(sync_error), 32'd1);
        check("pulse_short_unlock", 32'(locked), 32'd0);
        run_to(0, 3, "reach_pulse_release");
        short_pulse = 1'b0;
        relock();

        // Reset in the middle of a locked frame
        run_to(0, 0, "reach_pre_reset_tik");
        cyc();
        check("count_before_reset", 32'(frame_count), 32'd2);
        run_to(7, 5, "reach_reset_point");
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midrst_outputs", 32'({display_area, X, Y, frame_tik, locked, sync_error}), 32'd0);
        check("midrst_count", 32'(frame_count), 32'd0);
        relock();

        // 256 clean frames: counter wraps, no tick missed
        n_tik = 0; n_da = 0; n_err = 0;
        for (int f = 0; f < 256; f++) begin
            run_to(0, 0, "reach_frame");
            if (f == 255) check("count_255", 32'(frame_count), 32'd255);
            cyc();
        end
        check("tik_every_frame", 32'(n_tik), 32'd256);
        check("count_wrap", 32'(frame_count), 32'd0);
        check("tik_at_wrap", 32'(frame_tik), 32'd1);
        check("da_total", 32'(n_da), 32'(256 * HV * VV));
        check("no_err_clean", 32'(n_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
